timer_ctrl: RTL

Sequencing controller for the min:sec countdown timer datapath (minutes-ones, seconds-tens and seconds-ones down-counter digits). It does four jobs:
- loads the digits serially from a keypad;
- gates the 1 Hz count enable into the seconds-ones digit;
- handles start/pause/cancel;
- stops the chain at 0:00 and raises a timed alarm.

It sits between the keypad/button front end and the digit counter chain. The ripple between digits stays in the counters' terminal-count logic.

---
 rtl/timer_ctrl_if.sv | 27 ++
 rtl/timer_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_if.sv
// Bundle of keypad, button, tick and digit-chain signals that connect
// timer_ctrl to its front end and to the min:sec down-counter digits.
// The controller uses the slave view; whatever drives and observes it
// (front end plus digit chain) uses the master view.
interface timer_ctrl_if;
  logic       start;
  logic       stop;
  logic       key_valid;
  logic [3:0] key_data;
  logic       tick;
  logic       all_zero;
  logic [2:0] load_n;
  logic [3:0] load_data;
  logic       count_en;
  logic       done;
  logic       running;

  modport master (
    output start, stop, key_valid, key_data, tick, all_zero,
    input  load_n, load_data, count_en, done, running
  );

  modport slave (
    input  start, stop, key_valid, key_data, tick, all_zero,
    output load_n, load_data, count_en, done, running
  );
endinterface

// File: rtl/timer_ctrl.sv
// Sequencing controller for the min:sec countdown timer.
// It loads the three BCD digits serially from the keypad, from minutes-ones
// down to seconds-ones. It gates the 1 Hz tick into the seconds-ones digit
// and handles start, pause and cancel. When the digits reach 0:00 it stops
// the chain and holds a timed alarm.
// Borrows between digits stay in the counters' terminal-count logic, so this
// block only ever talks to the seconds-ones count enable and the load strobes.
module timer_ctrl #(
  parameter int ALARM_TICKS = 8
) (
  input  logic        clk,
  input  logic        clearn,
  timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_TICKS);
  localparam logic [1:0] PTR_FIRST   = 2'd2;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic [2:0] load_n_q, load_n_d;
  logic [3:0] load_data_q, load_data_d;
  logic       done_q, done_d;
  logic       running_q, running_d;

  logic       key_ok;
  logic [2:0] key_strobe;
  logic [1:0] ptr_next;
  logic [7:0] alarm_cnt_inc;

  // The seconds-tens digit only counts 0..5; the other two digits take any BCD value.
  always_comb begin
    key_ok        = 1'b0;
    key_strobe    = 3'b110;
    ptr_next      = PTR_FIRST;
    alarm_cnt_inc = alarm_cnt_q + 8'd1;
    case (ptr_q)
      2'd2: begin
        key_ok     = (bus.key_data <= 4'd9);
        key_strobe = 3'b011;
        ptr_next   = 2'd1;
      end
      2'd1: begin
        key_ok     = (bus.key_data <= 4'd5);
        key_strobe = 3'b101;
        ptr_next   = 2'd0;
      end
      default: begin
        key_ok     = (bus.key_data <= 4'd9);
        key_strobe = 3'b110;
        ptr_next   = PTR_FIRST;
      end
    endcase
  end

  // Next-state logic: stop beats start, a key beats start in IDLE, and load strobes last one cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    alarm_cnt_d = alarm_cnt_q;
    load_n_d    = 3'b111;
    load_data_d = load_data_q;

    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          if (key_ok) begin
            load_n_d    = key_strobe;
            load_data_d = bus.key_data;
            ptr_d       = ptr_next;
          end
        end else if (bus.start && !bus.stop && !bus.all_zero) begin
          state_d = RUN;
          ptr_d   = PTR_FIRST;
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_d = PAUSE;
        end else if (bus.all_zero) begin
          state_d     = DONE;
          alarm_cnt_d = 8'd0;
        end
      end

      PAUSE: begin
        if (bus.stop) begin
          state_d     = IDLE;
          load_n_d    = 3'b000;
          load_data_d = 4'h0;
          ptr_d       = PTR_FIRST;
        end else if (bus.start) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (bus.stop || bus.start) begin
          state_d = IDLE;
        end else if (bus.tick) begin
          alarm_cnt_d = alarm_cnt_inc;
          if (alarm_cnt_inc == ALARM_LIMIT) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        ptr_d   = PTR_FIRST;
      end
    endcase

    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // Controller state and registered outputs; clearn drops everything back to the idle values at once.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_FIRST;
      alarm_cnt_q <= 8'd0;
      load_n_q    <= 3'b111;
      load_data_q <= 4'h0;
      done_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      alarm_cnt_q <= alarm_cnt_d;
      load_n_q    <= load_n_d;
      load_data_q <= load_data_d;
      done_q      <= done_d;
      running_q   <= running_d;
    end
  end

  assign bus.load_n    = load_n_q;
  assign bus.load_data = load_data_q;
  assign bus.done      = done_q;
  assign bus.running   = running_q;
  assign bus.count_en  = (state_q == RUN) && bus.tick && !bus.all_zero;

endmodule
